// File: rtl/ph_uart_framer.sv
// Pulse-height UART framer: captures a height on each trigger-window close, queues it,
// and sends it as a 4-byte 8N1 frame (sync, hi, lo, hi^lo) on tx.
module ph_uart_framer #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             trig_in,
  input  logic [15:0]                      ph_in,
  output logic                             tx,
  output logic                             busy,
  output logic                             overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TMAX     = TW'(CLKS_PER_BIT-1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  logic [15:0]   mem [0:FIFO_DEPTH-1];
  logic [AW-1:0] wptr, rptr;
  logic          trig_q, cap, full, empty, push, pop;

  state_t        state, state_n;
  logic [TW-1:0] tmr, tmr_n;
  logic [2:0]    bit_idx, bit_n;
  logic [1:0]    byte_idx, byte_n;
  logic [7:0]    sh, sh_n;
  logic [15:0]   src, src_n;
  logic          tx_n, busy_n;

  function automatic logic [7:0] frame_byte(input logic [1:0] idx, input logic [15:0] h);
    case (idx)
      2'd0:    return SYNC_BYTE;
      2'd1:    return h[15:8];
      2'd2:    return h[7:0];
      default: return h[15:8] ^ h[7:0];
    endcase
  endfunction

  // Capture on the falling edge of the trigger window.
  assign cap   = trig_q & ~trig_in;
  assign full  = (fifo_level == FULL_LVL);
  assign empty = (fifo_level == '0);
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign push  = cap & (~full | pop);

  always_ff @(posedge clk)
    if (push) mem[wptr] <= ph_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_q     <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      trig_q <= trig_in;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      fifo_level <= fifo_level + LW'(1);
      else if (pop && !push) fifo_level <= fifo_level - LW'(1);
      if (cap && full && !pop) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    tmr_n   = tmr;
    bit_n   = bit_idx;
    byte_n  = byte_idx;
    sh_n    = sh;
    src_n   = src;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop     = 1'b1;
        src_n   = mem[rptr];
        byte_n  = 2'd0;
        state_n = LOAD;
      end
      LOAD: begin
        state_n = START;
        tmr_n   = '0;
        sh_n    = frame_byte(2'd0, src);
        tx_n    = 1'b0;
      end
      START: if (tmr == TMAX) begin
        tmr_n   = '0;
        bit_n   = '0;
        tx_n    = sh[0];
        state_n = DATA;
      end else tmr_n = tmr + TW'(1);
      DATA: if (tmr == TMAX) begin
        tmr_n = '0;
        if (bit_idx == 3'd7) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          bit_n = bit_idx + 3'd1;
          sh_n  = {1'b0, sh[7:1]};
          tx_n  = sh[1];
        end
      end else tmr_n = tmr + TW'(1);
      STOP: if (tmr == TMAX) begin
        tmr_n = '0;
        if (byte_idx != 2'd3) begin
          byte_n  = byte_idx + 2'd1;
          sh_n    = frame_byte(byte_idx + 2'd1, src);
          tx_n    = 1'b0;
          state_n = START;
        end else if (!empty) begin
          // Chain straight into the next frame so the gap is the single LOAD cycle.
          pop     = 1'b1;
          src_n   = mem[rptr];
          byte_n  = 2'd0;
          state_n = LOAD;
        end else state_n = IDLE;
      end else tmr_n = tmr + TW'(1);
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == START) || (state_n == DATA) || (state_n == STOP);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tmr      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      sh       <= '0;
      src      <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      tmr      <= tmr_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      sh       <= sh_n;
      src      <= src_n;
      tx       <= tx_n;
      busy     <= busy_n;
    end
  end
endmodule

// File: tb/tb_ph_uart_framer.sv
// Randomized bench for ph_uart_framer: transaction-level FIFO/transmitter model plus
// an offline UART decoder over per-cycle logs of tx/busy/level/overflow.
module tb_ph_uart_framer;
  localparam int CPB   = 4;
  localparam int FD    = 4;
  localparam int LW    = $clog2(FD+1);
  localparam int FRAME = 40*CPB;
  localparam int MAXC  = 40000;

  logic          clk = 1'b0;
  logic          reset_n, trig_in, tx, busy, overflow;
  logic [15:0]   ph_in;
  logic [LW-1:0] fifo_level;

  ph_uart_framer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(FD), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset_n(reset_n), .trig_in(trig_in), .ph_in(ph_in),
    .tx(tx), .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_tests = 0, n_fail = 0;
  logic tx_log   [0:MAXC-1];
  logic busy_log [0:MAXC-1];
  logic ovf_log  [0:MAXC-1];
  int   lvl_log  [0:MAXC-1];

  always @(posedge clk) cyc <= cyc + 1;

  // Log post-edge values of cycle cyc, away from the active edge.
  always @(negedge clk)
    if (cyc < MAXC) begin
      tx_log[cyc]   <= tx;
      busy_log[cyc] <= busy;
      ovf_log[cyc]  <= overflow;
      lvl_log[cyc]  <= int'(fifo_level);
    end

  int          ev_e[$];
  logic [15:0] ev_ph[$];
  int          c0;

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Trigger high for hi cycles then low; the capture edge is the next rising clock.
  task automatic fire(input logic [15:0] ph, input int hi);
    @(posedge clk); #1 trig_in = 1'b1;
    repeat (hi-1) begin @(posedge clk); #1; end
    @(posedge clk); #1 trig_in = 1'b0; ph_in = ph;
    ev_e.push_back(cyc + 1);
    ev_ph.push_back(ph);
  endtask

  function automatic int mlvl(input int c, input int qe[$], input int qp[$]);
    int n;
    n = 0;
    foreach (qe[k]) if (qe[k] <= c && qp[k] > c) n++;
    return n;
  endfunction

  task automatic scn_begin();
    ev_e.delete();
    ev_ph.delete();
    c0 = cyc;
  endtask

  task automatic check_scn(input int a, input int b);
    int          accE[$], accP[$];
    logic [15:0] accH[$];
    int          rx_t[$];
    logic [7:0]  rx_b[$];
    int          rx_ok[$];
    int          lastp, inq, p, i, idx, bcnt, ok;
    bit          popnow, drop;
    logic        v;
    logic [7:0]  by, exb[4];
    lastp = -1000000;
    drop  = 1'b0;
    // Model: a push is refused only when FD heights are waiting and none leaves this edge;
    // the transmitter takes a height one cycle after arrival or one frame+gap after the last.
    for (int n = 0; n < ev_e.size(); n++) begin
      inq = 0; popnow = 1'b0;
      foreach (accP[j]) begin
        if (accP[j] >= ev_e[n]) inq++;
        if (accP[j] == ev_e[n]) popnow = 1'b1;
      end
      if (inq < FD || popnow) begin
        p = (ev_e[n] + 1 > lastp + FRAME + 1) ? ev_e[n] + 1 : lastp + FRAME + 1;
        accE.push_back(ev_e[n]); accP.push_back(p); accH.push_back(ev_ph[n]);
        lastp = p;
      end else drop = 1'b1;
    end
    foreach (ev_e[n]) chk("lvl_at_capture", lvl_log[ev_e[n]], mlvl(ev_e[n], accE, accP));
    foreach (accP[k]) chk("lvl_at_pop", lvl_log[accP[k]], mlvl(accP[k], accE, accP));
    // Decode every 8N1 byte on the line; each bit must hold for CPB cycles.
    i = a + 1;
    while (i + 10*CPB - 1 <= b) begin
      if (tx_log[i-1] === 1'b1 && tx_log[i] === 1'b0) begin
        ok = 1; by = '0;
        for (int bi = 0; bi < 10; bi++) begin
          v = tx_log[i + bi*CPB];
          for (int k = 1; k < CPB; k++) if (tx_log[i + bi*CPB + k] !== v) ok = 0;
          if (bi >= 1 && bi <= 8) by[bi-1] = v;
          if (bi == 9 && v !== 1'b1) ok = 0;
        end
        rx_t.push_back(i); rx_b.push_back(by); rx_ok.push_back(ok);
        i += 10*CPB;
      end else i++;
    end
    chk("byte_count", rx_t.size(), 4*accH.size());
    foreach (accH[k]) begin
      exb[0] = 8'hA5; exb[1] = accH[k][15:8]; exb[2] = accH[k][7:0];
      exb[3] = accH[k][15:8] ^ accH[k][7:0];
      for (int bi = 0; bi < 4; bi++) begin
        idx = 4*k + bi;
        if (idx < rx_t.size()) begin
          chk("byte_val", int'(rx_b[idx]), int'(exb[bi]));
          chk("byte_time", rx_t[idx], accP[k] + 1 + bi*10*CPB);
          chk("framing", rx_ok[idx], 1);
        end
      end
      chk("busy_before", int'(busy_log[accP[k]]), 0);
      chk("busy_start", int'(busy_log[accP[k] + 1]), 1);
      chk("busy_end", int'(busy_log[accP[k] + FRAME]), 1);
    end
    bcnt = 0;
    for (int c = a; c <= b; c++) if (busy_log[c] === 1'b1) bcnt++;
    chk("busy_cycles", bcnt, FRAME*accH.size());
    chk("overflow", int'(ovf_log[b]), int'(drop));
  endtask

  task automatic scn_end();
    idle(ev_e.size()*(FRAME+1) + 30);
    check_scn(c0, cyc - 1);
  endtask

  int target, s, zeros, bcnt, lmax;

  initial begin
    reset_n = 1'b0; trig_in = 1'b0; ph_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_lvl", int'(fifo_level), 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Trigger low with no prior high, then held high: nothing captured.
    c0 = cyc;
    idle(30);
    trig_in = 1'b1; ph_in = 16'hBEEF;
    idle(30);
    zeros = 0; lmax = 0;
    for (int c = c0; c < cyc; c++) begin
      if (tx_log[c] !== 1'b1) zeros++;
      if (lvl_log[c] > lmax) lmax = lvl_log[c];
    end
    chk("nocap_tx", zeros, 0);
    chk("nocap_lvl", lmax, 0);

    scn_begin(); fire(16'h1234, 5); scn_end();
    scn_begin(); fire(16'hFFFF, 1); idle(250); fire(16'h0000, 2); scn_end();

    // Six events two cycles apart: one sent at once, four queued, one dropped.
    scn_begin();
    repeat (6) fire(16'($urandom), 1);
    scn_end();
    chk("burst_full_lvl", lvl_log[ev_e[4]], FD);
    chk("burst_ovf", int'(ovf_log[ev_e[5]]), 1);

    // Full FIFO, event lands on the edge the transmitter pops.
    reset_n = 1'b0; #1 reset_n = 1'b1;
    scn_begin();
    repeat (5) fire(16'($urandom), 1);
    target = ev_e[0] + FRAME + 2;
    while (cyc < target - 3) idle(1);
    fire(16'($urandom), 1);
    scn_end();
    chk("same_edge_E", ev_e[5], target);
    chk("same_edge_lvl", lvl_log[target], FD);
    chk("same_edge_ovf", int'(ovf_log[target]), 0);

    for (int r = 0; r < 3; r++) begin
      scn_begin();
      for (int n = 0; n < 8; n++) begin
        fire(16'($urandom), int'($urandom_range(1, 3)));
        idle(int'($urandom_range(0, 200)));
      end
      scn_end();
    end

    // Reset during data bits of byte 1 with heights queued and overflow set.
    scn_begin();
    repeat (6) fire(16'($urandom), 1);
    s = ev_e[0] + 2;
    while (cyc < s + 13*CPB) idle(1);
    chk("pre_rst_ovf", int'(overflow), 1);
    chk("pre_rst_tx_low_possible_lvl", int'(fifo_level), FD);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_tx", int'(tx), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_lvl", int'(fifo_level), 0);
    chk("midrst_ovf", int'(overflow), 0);
    idle(2);
    reset_n = 1'b1;
    c0 = cyc;
    idle(3*FRAME);
    zeros = 0; bcnt = 0; lmax = 0;
    for (int c = c0; c < cyc; c++) begin
      if (tx_log[c] !== 1'b1) zeros++;
      if (busy_log[c] === 1'b1) bcnt++;
      if (lvl_log[c] > lmax) lmax = lvl_log[c];
    end
    chk("postrst_tx", zeros, 0);
    chk("postrst_busy", bcnt, 0);
    chk("postrst_lvl", lmax, 0);

    scn_begin(); fire(16'($urandom), 3); scn_end();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
